// File: rtl/dac_frame_serializer.sv
// ============================================================================
// Module   : dac_frame_serializer
// Brief    : Serializes {CTRL_WORD, sample} frames MSB-first to a 12-bit serial
//            DAC. Optional macro SER_LDAC_SYNC_EN adds tick-synchronous LDAC.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dac_frame_serializer #(
  parameter int                DATA_W    = 12,
  parameter int                CTRL_W    = 4,
  parameter logic [CTRL_W-1:0] CTRL_WORD = 4'b0111,
  parameter int                SCLK_DIV  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              dac_sclk,
  output logic              dac_sdi,
  output logic              dac_cs_n,
  output logic              dac_ldac_n,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam int c_FW = CTRL_W + DATA_W;
  localparam int c_BW = $clog2(c_FW) + 1;
  localparam int c_DW = $clog2(SCLK_DIV) + 1;
  localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(c_FW - 1);
  localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(SCLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_SHIFT      = 2'd1,
    S_LATCH_WAIT = 2'd2,
    S_LATCH      = 2'd3
  } state_t;

  state_t          r_state;
  logic [c_FW-1:0] r_shift;
  logic [c_BW-1:0] r_bit;
  logic [c_DW-1:0] r_div;
  logic            r_sclk;
  logic            r_sdi;
  logic            r_cs_n;
  logic            r_ready;
  logic            r_done;
  logic            w_div_end;

`ifdef SER_LDAC_SYNC_EN
  logic            r_ldac_n;
  logic            r_overrun;
  logic            r_pend;
`else
  logic            w_unused;
  assign w_unused = tick;
`endif

  assign w_div_end = (r_div == c_DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit     <= '0;
      r_div     <= '0;
      r_sclk    <= 1'b0;
      r_sdi     <= 1'b0;
      r_cs_n    <= 1'b1;
      r_ready   <= 1'b0;
      r_done    <= 1'b0;
`ifdef SER_LDAC_SYNC_EN
      r_ldac_n  <= 1'b1;
      r_overrun <= 1'b0;
      r_pend    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef SER_LDAC_SYNC_EN
      // Ticks collapse into a single pending request; extra ones flag overrun.
      r_overrun <= 1'b0;
      if (tick && (r_state != S_LATCH)) begin
        r_pend <= 1'b1;
        if (r_pend) r_overrun <= 1'b1;
      end
`endif
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (sample_valid && r_ready) begin
            r_ready <= 1'b0;
            r_shift <= {CTRL_WORD, sample} << 1;
            r_sdi   <= CTRL_WORD[CTRL_W-1];
            r_cs_n  <= 1'b0;
            r_sclk  <= 1'b0;
            r_div   <= '0;
            r_bit   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_div <= r_div + c_DW'(1);
          if (w_div_end) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
            // Data advances on the falling edge so it is stable at the next rise.
            if (r_sclk) begin
              r_bit   <= r_bit + c_BW'(1);
              r_sdi   <= r_shift[c_FW-1];
              r_shift <= {r_shift[c_FW-2:0], 1'b0};
              if (r_bit == c_BIT_LAST) begin
                r_cs_n  <= 1'b1;
                r_sdi   <= 1'b0;
                r_done  <= 1'b1;
`ifdef SER_LDAC_SYNC_EN
                r_state <= S_LATCH_WAIT;
`else
                r_state <= S_IDLE;
`endif
              end
            end
          end
        end
`ifdef SER_LDAC_SYNC_EN
        S_LATCH_WAIT: begin
          if (r_pend || tick) begin
            r_state  <= S_LATCH;
            r_ldac_n <= 1'b0;
            r_div    <= '0;
            r_bit    <= '0;
            r_pend   <= 1'b0;
          end
        end
        S_LATCH: begin
          r_div <= r_div + c_DW'(1);
          if (w_div_end) begin
            r_div <= '0;
            r_bit <= r_bit + c_BW'(1);
            if (r_bit[0]) begin
              r_ldac_n <= 1'b1;
              r_ready  <= 1'b1;
              r_state  <= S_IDLE;
            end
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sample_ready = r_ready;
  assign dac_sclk     = r_sclk;
  assign dac_sdi      = r_sdi;
  assign dac_cs_n     = r_cs_n;
  assign busy         = (r_state != S_IDLE);
  assign frame_done   = r_done;
`ifdef SER_LDAC_SYNC_EN
  assign dac_ldac_n   = r_ldac_n;
  assign overrun      = r_overrun;
`else
  assign dac_ldac_n   = 1'b1;
  assign overrun      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dac_frame_serializer.sv
// ============================================================================
// Module   : tb_dac_frame_serializer
// Brief    : Scoreboard bench for dac_frame_serializer (follows SER_LDAC_SYNC_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dac_frame_serializer;

  localparam int SCLK_DIV = 2;
  localparam int FW       = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic [11:0] sample = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        dac_sclk;
  logic        dac_sdi;
  logic        dac_cs_n;
  logic        dac_ldac_n;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  dac_frame_serializer dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .dac_sclk     (dac_sclk),
    .dac_sdi      (dac_sdi),
    .dac_cs_n     (dac_cs_n),
    .dac_ldac_n   (dac_ldac_n),
    .busy         (busy),
    .frame_done   (frame_done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_q[$];
  bit          rand_en = 1'b0;
  bit          b2b     = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic step();
    @(negedge clk);
    tick = rand_en && ($urandom_range(0, 39) == 0);
  endtask

  task automatic send(input logic [11:0] s);
    bit ok = 1'b0;
    sample       = s;
    sample_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (sample_ready) begin
        exp_q.push_back({4'b0111, s});
        ok = 1'b1;
        break;
      end
      step();
    end
    check("send_accepted", 32'(ok), 1);
    step();
    sample_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      step();
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    check("frame_done_seen", 32'(ok), 1);
  endtask

  task automatic wait_ready();
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (sample_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("ready_seen", 32'(ok), 1);
  endtask

  // Monitor: rebuilds frames from the serial pins and models the LDAC rules.
  bit          in_frame = 1'b0;
  bit          end_now;
  bit          in_latch;
  int          low_cnt, nbits, first_rise;
  int          hi_cnt = 0;
  logic [15:0] bits;
  logic        prev_sclk = 1'b0;
  int          m_left = 0;
  bit          m_pend = 1'b0, m_wait = 1'b0, m_ovr = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      end_now = 1'b0;
`ifdef SER_LDAC_SYNC_EN
      check("ldac_n", 32'(dac_ldac_n), (m_left > 0) ? 0 : 1);
      check("overrun", 32'(overrun), 32'(m_ovr));
`else
      check("ldac_n", 32'(dac_ldac_n), 1);
      check("overrun", 32'(overrun), 0);
`endif
      if (rst) begin
        in_frame = 1'b0;
        exp_q.delete();
        m_left = 0;
        m_pend = 1'b0;
        m_wait = 1'b0;
        m_ovr  = 1'b0;
        hi_cnt = 0;
      end else begin
        if (!dac_cs_n) begin
          if (!in_frame) begin
            in_frame   = 1'b1;
            low_cnt    = 0;
            nbits      = 0;
            first_rise = -1;
            bits       = '0;
            check("start_busy", 32'(busy), 1);
            check("start_ready", 32'(sample_ready), 0);
            if (b2b) check("cs_high_gap", hi_cnt, 2);
          end
          if (dac_sclk && !prev_sclk) begin
            bits = {bits[14:0], dac_sdi};
            nbits++;
            if (first_rise < 0) first_rise = low_cnt;
          end
          low_cnt++;
        end else if (in_frame) begin
          end_now  = 1'b1;
          in_frame = 1'b0;
          hi_cnt   = 1;
          check("frame_done", 32'(frame_done), 1);
          check("end_sclk", 32'(dac_sclk), 0);
          check("end_sdi", 32'(dac_sdi), 0);
          check("cs_low_cycles", low_cnt, 2 * FW * SCLK_DIV);
          check("bit_count", nbits, FW);
          check("first_rise", first_rise, SCLK_DIV);
          if (exp_q.size() == 0) check("frame_expected", 0, 1);
          else check("frame_data", 32'(bits), 32'(exp_q.pop_front()));
        end else begin
          hi_cnt++;
        end
        if (frame_done && !end_now) check("stray_done", 1, 0);
        if (end_now) m_wait = 1'b1;
        in_latch = (m_left > 0);
        m_ovr    = tick && m_pend && !in_latch;
        if (in_latch) begin
          m_left--;
        end else begin
          if (tick) m_pend = 1'b1;
          if (m_wait && m_pend) begin
            m_left = 2 * SCLK_DIV;
            m_wait = 1'b0;
            m_pend = 1'b0;
          end
        end
      end
      prev_sclk = dac_sclk;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    check("rst_cs_n", 32'(dac_cs_n), 1);
    check("rst_sclk", 32'(dac_sclk), 0);
    check("rst_sdi", 32'(dac_sdi), 0);
    check("rst_ldac_n", 32'(dac_ldac_n), 1);
    check("rst_ready", 32'(sample_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_overrun", 32'(overrun), 0);
    rst = 1'b0;

    // Known frame, then a late tick
    send(12'hABC);
    wait_done();
    repeat (10) step();
    tick = 1'b1;
    step();
    wait_ready();

    // Tick during bit 5
    send(12'($urandom));
    repeat (21) step();
    tick = 1'b1;
    wait_done();
    wait_ready();

    // Two ticks in one frame
    send(12'($urandom));
    repeat (10) step();
    tick = 1'b1;
    repeat (21) step();
    tick = 1'b1;
    wait_done();
    wait_ready();

    // Reset during bit 7, then a zero sample
    send(12'($urandom));
    repeat (28) step();
    rst = 1'b1;
    step();
    check("abort_cs_n", 32'(dac_cs_n), 1);
    check("abort_sclk", 32'(dac_sclk), 0);
    check("abort_sdi", 32'(dac_sdi), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_ready", 32'(sample_ready), 0);
    rst = 1'b0;
    send(12'h000);
    wait_done();

`ifndef SER_LDAC_SYNC_EN
    // Back-to-back frames
    send(12'($urandom));
    step();
    b2b = 1'b1;
    for (int i = 0; i < 3; i++) send(12'($urandom));
    wait_done();
    b2b = 1'b0;
`endif

    rand_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(12'($urandom));
      repeat ($urandom_range(0, 80)) step();
    end
    rand_en = 1'b0;
    repeat (300) step();
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
